// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: A + ~B + 1 evaluated one 4-bit lookahead slice per clock,
// LSB nibble first, with the inter-nibble carry held in a register.

module nss_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c0,
    output logic [3:0] o_sum,
    output logic       o_c3,
    output logic       o_c4
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_c4;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat sum of products so no ripple exists inside the slice.
    assign w_c1 = w_g[0]
                | (w_p[0] & i_c0);
    assign w_c2 = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_c0);
    assign w_c3 = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c4 = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

    assign o_sum = w_p ^ {w_c3, w_c2, w_c1, i_c0};
    assign o_c3  = w_c3;
    assign o_c4  = w_c4;
endmodule

module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bn;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_busy;
    logic             r_done;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic             w_c3;
    logic             w_c4;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;

    assign w_last = (r_cnt == CW'(NIB - 1));

    always_comb begin
        w_a_nib     = 4'h0;
        w_b_nib     = 4'h0;
        w_diff_next = r_diff;
        for (int k = 0; k < NIB; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_nib               = r_a[4*k +: 4];
                w_b_nib               = r_bn[4*k +: 4];
                w_diff_next[4*k +: 4] = w_sum;
            end
        end
    end

    nss_cla4 u_slice (
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_c0  (r_carry),
        .o_sum (w_sum),
        .o_c3  (w_c3),
        .o_c4  (w_c4)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_bn     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_bn     <= ~i_b;
                        r_carry  <= 1'b1;
                        r_cnt    <= '0;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_c4;
                    if (w_last) begin
                        // The last slice holds the MSB, so its c3/c4 are the sign-bit carries.
                        r_borrow <= ~w_c4;
                        r_ovf    <= w_c3 ^ w_c4;
                        r_zero   <= (w_diff_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow;
    assign o_overflow   = r_ovf;
    assign o_zero       = r_zero;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor at WIDTH=16: latency, results, flags,
// back-to-back accept, start ignored while running, and reset abort.

module tb_nibble_serial_subtractor;
    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_a          (a),
        .i_b          (b),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow_out (borrow_out),
        .o_overflow   (overflow),
        .o_zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start pulse; returns at the falling edge right after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_tests++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL reset_diff got %h exp 0000", diff); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b exp 0", borrow_out); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b exp 0", zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        start_op(16'h1234, 16'h0234);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early got %b exp 0", done); end
        wait_done(cyc);
        n_tests++; if (cyc !== NIB + 1) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", cyc, NIB + 1); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
        n_tests++; if (diff !== 16'h1000) begin n_fail++; $display("FAIL basic_diff got %h exp 1000", diff); end
        n_tests++; if ({borrow_out, overflow, zero} !== 3'b000) begin n_fail++; $display("FAIL basic_flags got %b exp 000", {borrow_out, overflow, zero}); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        n_tests++; if (diff !== 16'h1000) begin n_fail++; $display("FAIL basic_diff_hold got %h exp 1000", diff); end
    endtask

    task automatic test_borrow_chain;
        int cyc;
        start_op(16'h1000, 16'h0001);
        wait_done(cyc);
        n_tests++; if (cyc !== NIB + 1) begin n_fail++; $display("FAIL chain_latency got %0d exp %0d", cyc, NIB + 1); end
        n_tests++; if (diff !== 16'h0FFF) begin n_fail++; $display("FAIL chain_diff got %h exp 0fff", diff); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL chain_borrow got %b exp 0", borrow_out); end
    endtask

    task automatic test_flags;
        int cyc;
        start_op(16'h0000, 16'h0001);
        wait_done(cyc);
        n_tests++; if (diff !== 16'hFFFF) begin n_fail++; $display("FAIL under_diff got %h exp ffff", diff); end
        n_tests++; if (borrow_out !== 1'b1) begin n_fail++; $display("FAIL under_borrow got %b exp 1", borrow_out); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL under_ovf got %b exp 0", overflow); end
        start_op(16'h8000, 16'h0001);
        wait_done(cyc);
        n_tests++; if (diff !== 16'h7FFF) begin n_fail++; $display("FAIL sovf_diff got %h exp 7fff", diff); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sovf_ovf got %b exp 1", overflow); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL sovf_borrow got %b exp 0", borrow_out); end
        n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sovf_zero got %b exp 0", zero); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        a     = 16'h5A5A;
        b     = 16'h5A5A;
        start = 1'b1;
        @(negedge clk);
        a = 16'h0003;
        b = 16'h0005;
        wait_done(cyc);
        n_tests++; if (cyc !== NIB + 1) begin n_fail++; $display("FAIL b2b_latency1 got %0d exp %0d", cyc, NIB + 1); end
        n_tests++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL b2b_diff1 got %h exp 0000", diff); end
        n_tests++; if (zero !== 1'b1) begin n_fail++; $display("FAIL b2b_zero1 got %b exp 1", zero); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL b2b_borrow1 got %b exp 0", borrow_out); end
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept got busy=%b done=%b exp busy=1 done=0", busy, done); end
        n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL b2b_zero_clear got %b exp 0", zero); end
        wait_done(cyc);
        n_tests++; if (cyc !== NIB + 1) begin n_fail++; $display("FAIL b2b_latency2 got %0d exp %0d", cyc, NIB + 1); end
        n_tests++; if (diff !== 16'hFFFE) begin n_fail++; $display("FAIL b2b_diff2 got %h exp fffe", diff); end
        n_tests++; if (borrow_out !== 1'b1) begin n_fail++; $display("FAIL b2b_borrow2 got %b exp 1", borrow_out); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf2 got %b exp 0", overflow); end
    endtask

    task automatic test_start_in_run;
        int n_done = 0;
        int done_cyc = 0;
        logic [WIDTH-1:0] got = '0;
        start_op(16'h0F00, 16'h0100);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            if (done) begin
                n_done++;
                done_cyc = c;
                got      = diff;
            end
            @(negedge clk);
        end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL run_ignore_pulses got %0d exp 1", n_done); end
        n_tests++; if (done_cyc !== NIB + 1) begin n_fail++; $display("FAIL run_ignore_latency got %0d exp %0d", done_cyc, NIB + 1); end
        n_tests++; if (got !== 16'h0E00) begin n_fail++; $display("FAIL run_ignore_diff got %h exp 0e00", got); end
    endtask

    task automatic test_reset_mid_run;
        int n_done = 0;
        int cyc;
        start_op(16'h1234, 16'h0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl got busy=%b done=%b exp 0 0", busy, done); end
        n_tests++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL abort_diff got %h exp 0000", diff); end
        n_tests++; if ({borrow_out, overflow, zero} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b exp 000", {borrow_out, overflow, zero}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", n_done); end
        start_op(16'h00FF, 16'h000F);
        wait_done(cyc);
        n_tests++; if (cyc !== NIB + 1) begin n_fail++; $display("FAIL post_rst_latency got %0d exp %0d", cyc, NIB + 1); end
        n_tests++; if (diff !== 16'h00F0) begin n_fail++; $display("FAIL post_rst_diff got %h exp 00f0", diff); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow_chain;
        test_flags;
        test_back_to_back;
        test_start_in_run;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing A − B as A + ~B + 1, one 4-bit carry-lookahead slice per clock, LSB nibble first. The inter-nibble carry is held in a register between cycles. A start/busy/done handshake frames each operation. It is the subtract-direction companion to the team's 4-bit CLA adder and is used where area matters more than single-cycle latency.

## Interface
- WIDTH, default 16: operand width in bits; must be a multiple of 4 and ≥ 8.
- NIB, derived = WIDTH/4: number of nibble cycles per operation.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when the block can accept
- a  in  WIDTH  minuend; sampled on the accepting edge only
- b  in  WIDTH  subtrahend; sampled on the accepting edge only
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on
- diff  out  WIDTH  a − b, modulo 2^WIDTH
- borrow_out  out  1  unsigned borrow: 1 iff a < b (unsigned); equals the inverted final carry
- overflow  out  1  signed overflow: the operand signs differ and diff's sign differs from a's sign
- zero  out  1  diff == 0

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Accepting: the block accepts start in IDLE or DONE (back-to-back operations allowed).
- On accept:
  - latch a into the operand register; latch ~b into the operand register
  - set the carry register to 1
  - clear the nibble counter and the diff register
  - go to RUN; busy=1
- While in RUN, start is ignored and a/b changes have no effect.
- RUN cycle k (k = 0..NIB−1):
  - one 4-bit CLA slice takes nibble k of A, nibble k of ~B, and the carry register
  - generate/propagate: p = a^b, g = a&b per bit, with full lookahead for c1..c4
  - sum nibble is written to diff[4k+3:4k]; c4 is written to the carry register
  - the counter increments
- After the k = NIB−1 edge:
  - borrow_out = ~c4 of the top nibble
  - overflow = carry into the MSB XOR carry out of the MSB
  - zero = (final diff == 0)
  - state goes to DONE; busy=0, done=1
- DONE lasts one cycle, then IDLE unless start is accepted in DONE.
- diff, borrow_out, overflow and zero hold their values until the next accept.
- On accept, diff, borrow_out, overflow and zero clear to 0. They are undefined to consumers while busy=1 and are only meaningful when done=1 or afterwards.
- Counter width is ceil(log2(NIB)). The counter wraps only via accept and never free-runs.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy=0; done=0; diff=0; borrow_out=0; overflow=0; zero=0; counter=0; carry register=0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse follows, and the first start after rst_n deasserts is accepted normally.
- Latency: start accepted at edge T → busy=1 from T to T+NIB; done=1 in the cycle after edge T+NIB, with results valid in the same cycle.
- Throughput: one result per NIB+1 cycles when start is held high continuously.
- A start accepted in DONE re-enters RUN at that edge. done is high for exactly that one DONE cycle and the new operation proceeds identically.
- Critical path: one 4-bit lookahead slice plus the register setup. There is no ripple across nibbles within a cycle.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234 → done 5 cycles after the accepting edge; diff=0x1000, borrow_out=0, overflow=0, zero=0.
- a=0x1000, b=0x0001 → diff=0x0FFF, borrow_out=0: the borrow chain crosses nibbles 0→1→2→3 through the carry register.
- a=0x0000, b=0x0001 → diff=0xFFFF, borrow_out=1, overflow=0. Also a=0x8000, b=0x0001 → diff=0x7FFF, overflow=1, borrow_out=0.
- a=b=0x5A5A → diff=0x0000, zero=1, borrow_out=0. Then, with start held high, a=0x0003, b=0x0005 accepted in the DONE cycle → the next done 5 cycles later with diff=0xFFFE, borrow_out=1.
- Pulse start with new operands in RUN cycle 2 → ignored; the original result is produced unchanged and only one done pulse occurs.
- Drop rst_n in RUN cycle 1 → all outputs 0 immediately and no done pulse. After release, a=0x00FF, b=0x000F → diff=0x00F0.
